// File: rtl/debug_port_ng.sv
// debug_port_ng: parametrised debug bridge between an 8-bit host register
// interface and the CPU core. The host loads the address and write data a byte
// at a time, then launches a request/acknowledge transaction. On acknowledge,
// the transaction captures one of four source words for lane-by-lane readback.
// Optional feature macro: DEBUG_PORT_TIMEOUT_EN aborts a request that has not
// been acknowledged after TIMEOUT cycles and flags ERR_TMO.
module debug_port_ng #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_STEP  = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [2:0]              HOST_ADDR,
  input  logic [7:0]              HOST_DIN,
  output logic [7:0]              HOST_DOUT,
  input  logic                    HOST_WR,
  input  logic                    HOST_RD,
  output logic                    DEBUG_STOP,
  input  logic                    DEBUG_STOPPED,
  output logic                    DEBUG_REQ,
  input  logic                    DEBUG_ACK,
  output logic [2:0]              DEBUG_OP,
  output logic [4:0]              DEBUG_SEL,
  output logic [ADDR_WIDTH-1:0]   DEBUG_MEM_ADDR,
  output logic [DATA_WIDTH-1:0]   DEBUG_MEM_DATA_OUT,
  input  logic [4*DATA_WIDTH-1:0] DEBUG_SRC_DATA
);

  localparam int LANES  = DATA_WIDTH / 8;
  localparam int RPTR_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_POST} state_t;

  state_t                state;
  logic                  stop;
  logic                  autoinc;
  logic                  err_busy;
  logic                  err_tmo;
  logic [2:0]            op;
  logic [4:0]            sel;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] result;
  logic [RPTR_W-1:0]     rptr;
  logic [1:0]            src_sel;

`ifdef DEBUG_PORT_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TMO_W-1:0] tmo_cnt;
`endif

  logic                  busy;
  logic                  wr_ctrl;
  logic                  wr_op;
  logic                  wr_addr;
  logic                  wr_wdata;
  logic                  wr_reject;
  logic                  rd_rdata;
  logic [ADDR_WIDTH-1:0] addr_shift;
  logic [DATA_WIDTH-1:0] wdata_shift;
  logic [DATA_WIDTH-1:0] src_word;

  assign busy        = (state != S_IDLE);
  assign wr_ctrl     = HOST_WR && (HOST_ADDR == 3'd0);
  assign wr_op       = HOST_WR && (HOST_ADDR == 3'd1);
  assign wr_addr     = HOST_WR && (HOST_ADDR == 3'd2);
  assign wr_wdata    = HOST_WR && (HOST_ADDR == 3'd3);
  assign wr_reject   = busy && (wr_op || wr_addr || wr_wdata);
  assign rd_rdata    = HOST_RD && (HOST_ADDR == 3'd4);
  // Bytes enter at the bottom and push older bytes towards the MSB.
  assign addr_shift  = (addr << 8) | ADDR_WIDTH'(HOST_DIN);
  assign wdata_shift = (wdata << 8) | DATA_WIDTH'(HOST_DIN);
  assign src_word    = DEBUG_SRC_DATA[src_sel*DATA_WIDTH +: DATA_WIDTH];

  // Host-owned configuration: halt request, auto-increment, capture source, write data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stop    <= 1'b0;
      autoinc <= 1'b0;
      src_sel <= 2'd0;
      wdata   <= '0;
    end else begin
      if (wr_ctrl) begin
        stop    <= HOST_DIN[0];
        autoinc <= HOST_DIN[1];
      end
      if (wr_wdata && !busy) wdata <= wdata_shift;
      if (HOST_WR && (HOST_ADDR == 3'd5)) src_sel <= HOST_DIN[1:0];
    end
  end

  // Transaction engine with the address counter, result capture, readback pointer and error flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      op       <= 3'd0;
      sel      <= 5'd0;
      addr     <= '0;
      result   <= '0;
      rptr     <= '0;
      err_busy <= 1'b0;
      err_tmo  <= 1'b0;
`ifdef DEBUG_PORT_TIMEOUT_EN
      tmo_cnt  <= '0;
`endif
    end else begin
      if (wr_ctrl && HOST_DIN[2]) begin
        err_busy <= 1'b0;
        err_tmo  <= 1'b0;
      end
      if (wr_reject) err_busy <= 1'b1;
      if (rd_rdata) rptr <= (rptr == RPTR_W'(LANES - 1)) ? '0 : rptr + RPTR_W'(1);
      case (state)
        S_IDLE: begin
          if (wr_op) begin
            {sel, op} <= HOST_DIN;
            state     <= S_REQ;
`ifdef DEBUG_PORT_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end else if (wr_addr) begin
            addr <= addr_shift;
          end
        end
        S_REQ: begin
          if (DEBUG_ACK) begin
            result <= src_word;
            rptr   <= '0;
            state  <= S_POST;
          end
`ifdef DEBUG_PORT_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            err_tmo <= 1'b1;
            state   <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        S_POST: begin
          if (autoinc && op[2]) addr <= addr + ADDR_WIDTH'(ADDR_STEP);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Zero-latency host readback mux.
  always_comb begin
    HOST_DOUT = 8'h00;
    case (HOST_ADDR)
      3'd0:    HOST_DOUT = {4'b0000, err_tmo, err_busy, busy, DEBUG_STOPPED};
      3'd1:    HOST_DOUT = {sel, op};
      3'd2:    HOST_DOUT = addr[7:0];
      3'd3:    HOST_DOUT = wdata[7:0];
      3'd4:    HOST_DOUT = result[rptr*8 +: 8];
      3'd5:    HOST_DOUT = {6'b000000, src_sel};
      default: HOST_DOUT = 8'h00;
    endcase
  end

  assign DEBUG_STOP         = stop;
  assign DEBUG_REQ          = (state == S_REQ);
  assign DEBUG_OP           = op;
  assign DEBUG_SEL          = sel;
  assign DEBUG_MEM_ADDR     = addr;
  assign DEBUG_MEM_DATA_OUT = wdata;

endmodule

// File: tb/tb_debug_port_ng.sv
// tb_debug_port_ng: scenario-driven bench for debug_port_ng. Expected readback
// bytes are queued when a transaction is launched and popped as RDATA is read.
// With DEBUG_PORT_TIMEOUT_EN defined, the timeout abort is exercised; otherwise
// the bench checks that a request waits indefinitely.
module tb_debug_port_ng;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [2:0]  HOST_ADDR = 3'd0;
  logic [7:0]  HOST_DIN = 8'h00;
  logic [7:0]  HOST_DOUT;
  logic        HOST_WR = 1'b0;
  logic        HOST_RD = 1'b0;
  logic        DEBUG_STOP;
  logic        DEBUG_STOPPED = 1'b0;
  logic        DEBUG_REQ;
  logic        DEBUG_ACK = 1'b0;
  logic [2:0]  DEBUG_OP;
  logic [4:0]  DEBUG_SEL;
  logic [15:0] DEBUG_MEM_ADDR;
  logic [15:0] DEBUG_MEM_DATA_OUT;
  logic [63:0] DEBUG_SRC_DATA = 64'h0;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  debug_port_ng #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .ADDR_STEP(2), .TIMEOUT(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .HOST_ADDR(HOST_ADDR), .HOST_DIN(HOST_DIN),
    .HOST_DOUT(HOST_DOUT), .HOST_WR(HOST_WR), .HOST_RD(HOST_RD),
    .DEBUG_STOP(DEBUG_STOP), .DEBUG_STOPPED(DEBUG_STOPPED), .DEBUG_REQ(DEBUG_REQ),
    .DEBUG_ACK(DEBUG_ACK), .DEBUG_OP(DEBUG_OP), .DEBUG_SEL(DEBUG_SEL),
    .DEBUG_MEM_ADDR(DEBUG_MEM_ADDR), .DEBUG_MEM_DATA_OUT(DEBUG_MEM_DATA_OUT),
    .DEBUG_SRC_DATA(DEBUG_SRC_DATA)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    HOST_ADDR = a;
    HOST_DIN  = d;
    HOST_WR   = 1'b1;
    step();
    HOST_WR   = 1'b0;
  endtask

  task automatic host_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge CLK);
    HOST_ADDR = a;
    #1;
    d = HOST_DOUT;
  endtask

  task automatic rdata_read(output logic [7:0] d);
    @(negedge CLK);
    HOST_ADDR = 3'd4;
    HOST_RD   = 1'b1;
    #1;
    d = HOST_DOUT;
    step();
    HOST_RD   = 1'b0;
  endtask

  task automatic pulse_ack();
    DEBUG_ACK = 1'b1;
    step();
    DEBUG_ACK = 1'b0;
  endtask

  // Pops one expected byte and compares it against a fresh RDATA read.
  task automatic test_rdata_lane(input string name);
    logic [7:0] got;
    logic [7:0] exp;
    rdata_read(got);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s: got %02h, no expected byte queued", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL %s: got %02h expected %02h", name, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    RESET = 1'b1;
    step(); step();
    RESET = 1'b0;
    host_read(3'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("[TB] FAIL reset_ctrl: got %02h expected 00", d); end
    host_read(3'd1, d);
    checks++; if (d !== 8'h00) begin failures++; $display("[TB] FAIL reset_op: got %02h expected 00", d); end
    host_read(3'd4, d);
    checks++; if (d !== 8'h00) begin failures++; $display("[TB] FAIL reset_rdata: got %02h expected 00", d); end
    host_read(3'd6, d);
    checks++; if (d !== 8'h00) begin failures++; $display("[TB] FAIL reset_reg6: got %02h expected 00", d); end
    checks++; if (DEBUG_MEM_ADDR !== 16'h0000) begin failures++; $display("[TB] FAIL reset_addr: got %04h expected 0000", DEBUG_MEM_ADDR); end
    checks++; if (DEBUG_REQ !== 1'b0) begin failures++; $display("[TB] FAIL reset_req: got %b expected 0", DEBUG_REQ); end
    checks++; if (DEBUG_STOP !== 1'b0) begin failures++; $display("[TB] FAIL reset_stop: got %b expected 0", DEBUG_STOP); end
  endtask

  task automatic test_stop_and_wdata();
    logic [7:0] d;
    host_write(3'd0, 8'h01);
    checks++; if (DEBUG_STOP !== 1'b1) begin failures++; $display("[TB] FAIL stop_set: got %b expected 1", DEBUG_STOP); end
    DEBUG_STOPPED = 1'b1;
    host_read(3'd0, d);
    checks++; if (d !== 8'h01) begin failures++; $display("[TB] FAIL stopped_ctrl: got %02h expected 01", d); end
    host_write(3'd0, 8'h00);
    DEBUG_STOPPED = 1'b0;
    checks++; if (DEBUG_STOP !== 1'b0) begin failures++; $display("[TB] FAIL stop_clear: got %b expected 0", DEBUG_STOP); end
    host_write(3'd3, 8'hCA);
    host_write(3'd3, 8'hFE);
    checks++; if (DEBUG_MEM_DATA_OUT !== 16'hCAFE) begin failures++; $display("[TB] FAIL wdata_shift: got %04h expected CAFE", DEBUG_MEM_DATA_OUT); end
  endtask

  task automatic test_autoinc_transaction();
    logic [7:0] d;
    host_write(3'd2, 8'h12);
    host_write(3'd2, 8'h34);
    checks++; if (DEBUG_MEM_ADDR !== 16'h1234) begin failures++; $display("[TB] FAIL addr_load: got %04h expected 1234", DEBUG_MEM_ADDR); end
    host_write(3'd0, 8'h02);
    DEBUG_SRC_DATA = {16'h4444, 16'h3333, 16'h2222, 16'hBEEF};
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    host_write(3'd1, 8'h04);
    checks++; if (DEBUG_REQ !== 1'b1) begin failures++; $display("[TB] FAIL main_req_high: got %b expected 1", DEBUG_REQ); end
    host_read(3'd0, d);
    checks++; if (d !== 8'h02) begin failures++; $display("[TB] FAIL main_busy: got %02h expected 02", d); end
    step(); step();
    pulse_ack();
    checks++; if (DEBUG_REQ !== 1'b0) begin failures++; $display("[TB] FAIL main_req_drop: got %b expected 0", DEBUG_REQ); end
    checks++; if (DEBUG_MEM_ADDR !== 16'h1234) begin failures++; $display("[TB] FAIL main_addr_hold: got %04h expected 1234", DEBUG_MEM_ADDR); end
    step();
    checks++; if (DEBUG_MEM_ADDR !== 16'h1236) begin failures++; $display("[TB] FAIL main_addr_inc: got %04h expected 1236", DEBUG_MEM_ADDR); end
    host_read(3'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("[TB] FAIL main_idle: got %02h expected 00", d); end
    test_rdata_lane("main_rdata0");
    test_rdata_lane("main_rdata1");
    test_rdata_lane("main_rdata_wrap");
  endtask

  task automatic test_addr_wrap();
    logic [7:0] d;
    host_write(3'd5, 8'h01);
    DEBUG_SRC_DATA[31:16] = 16'hA55A;
    host_write(3'd2, 8'hFF);
    host_write(3'd2, 8'hFE);
    checks++; if (DEBUG_MEM_ADDR !== 16'hFFFE) begin failures++; $display("[TB] FAIL wrap_load: got %04h expected FFFE", DEBUG_MEM_ADDR); end
    exp_q.push_back(8'h5A); exp_q.push_back(8'hA5);
    host_write(3'd1, 8'h05);
    checks++; if (DEBUG_OP !== 3'd5) begin failures++; $display("[TB] FAIL wrap_op: got %0d expected 5", DEBUG_OP); end
    pulse_ack();
    step();
    checks++; if (DEBUG_MEM_ADDR !== 16'h0000) begin failures++; $display("[TB] FAIL wrap_addr: got %04h expected 0000", DEBUG_MEM_ADDR); end
    host_read(3'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("[TB] FAIL wrap_min_idle: got %02h expected 00", d); end
    test_rdata_lane("wrap_rdata0");
    test_rdata_lane("wrap_rdata1");
  endtask

  task automatic test_non_mem_op();
    logic [7:0] d;
    host_write(3'd5, 8'h02);
    DEBUG_SRC_DATA[47:32] = 16'h1357;
    exp_q.push_back(8'h57); exp_q.push_back(8'h13);
    host_write(3'd1, 8'h23);
    checks++; if (DEBUG_SEL !== 5'd4) begin failures++; $display("[TB] FAIL nonmem_sel: got %0d expected 4", DEBUG_SEL); end
    host_read(3'd1, d);
    checks++; if (d !== 8'h23) begin failures++; $display("[TB] FAIL nonmem_opread: got %02h expected 23", d); end
    pulse_ack();
    step();
    checks++; if (DEBUG_MEM_ADDR !== 16'h0000) begin failures++; $display("[TB] FAIL nonmem_no_inc: got %04h expected 0000", DEBUG_MEM_ADDR); end
    test_rdata_lane("nonmem_rdata0");
    test_rdata_lane("nonmem_rdata1");
  endtask

  task automatic test_busy_errors();
    logic [7:0] d;
    host_write(3'd2, 8'h00);
    host_write(3'd2, 8'h40);
    DEBUG_SRC_DATA[47:32] = 16'h2468;
    exp_q.push_back(8'h68); exp_q.push_back(8'h24);
    host_write(3'd1, 8'h04);
    host_write(3'd1, 8'h07);
    host_write(3'd2, 8'h99);
    host_write(3'd3, 8'h11);
    host_read(3'd1, d);
    checks++; if (d !== 8'h04) begin failures++; $display("[TB] FAIL busy_op_kept: got %02h expected 04", d); end
    host_read(3'd0, d);
    checks++; if (d !== 8'h06) begin failures++; $display("[TB] FAIL busy_err_set: got %02h expected 06", d); end
    checks++; if (DEBUG_MEM_ADDR !== 16'h0040) begin failures++; $display("[TB] FAIL busy_addr_kept: got %04h expected 0040", DEBUG_MEM_ADDR); end
    checks++; if (DEBUG_MEM_DATA_OUT !== 16'hCAFE) begin failures++; $display("[TB] FAIL busy_wdata_kept: got %04h expected CAFE", DEBUG_MEM_DATA_OUT); end
    pulse_ack();
    step();
    checks++; if (DEBUG_MEM_ADDR !== 16'h0042) begin failures++; $display("[TB] FAIL busy_addr_inc: got %04h expected 0042", DEBUG_MEM_ADDR); end
    host_read(3'd0, d);
    checks++; if (d !== 8'h04) begin failures++; $display("[TB] FAIL busy_err_sticky: got %02h expected 04", d); end
    host_write(3'd0, 8'h06);
    host_read(3'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("[TB] FAIL busy_err_clear: got %02h expected 00", d); end
    test_rdata_lane("busy_rdata0");
    test_rdata_lane("busy_rdata1");
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    int req_cycles;
    DEBUG_SRC_DATA[47:32] = 16'hFFFF;
`ifdef DEBUG_PORT_TIMEOUT_EN
    exp_q.push_back(8'h68); exp_q.push_back(8'h24);
    host_write(3'd1, 8'h04);
    req_cycles = 0;
    while (DEBUG_REQ === 1'b1 && req_cycles < 20) begin
      req_cycles++;
      step();
    end
    checks++; if (req_cycles != 4) begin failures++; $display("[TB] FAIL tmo_req_cycles: got %0d expected 4", req_cycles); end
    host_read(3'd0, d);
    checks++; if (d !== 8'h08) begin failures++; $display("[TB] FAIL tmo_ctrl: got %02h expected 08", d); end
    checks++; if (DEBUG_MEM_ADDR !== 16'h0042) begin failures++; $display("[TB] FAIL tmo_no_inc: got %04h expected 0042", DEBUG_MEM_ADDR); end
    pulse_ack();
    step();
    test_rdata_lane("tmo_rdata0");
    test_rdata_lane("tmo_rdata1");
    host_write(3'd0, 8'h06);
    host_read(3'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("[TB] FAIL tmo_clear: got %02h expected 00", d); end
`else
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    host_write(3'd1, 8'h04);
    req_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (DEBUG_REQ === 1'b1) req_cycles++;
      step();
    end
    checks++; if (req_cycles != 10) begin failures++; $display("[TB] FAIL wait_req_cycles: got %0d expected 10", req_cycles); end
    host_read(3'd0, d);
    checks++; if (d !== 8'h02) begin failures++; $display("[TB] FAIL wait_ctrl: got %02h expected 02", d); end
    pulse_ack();
    step();
    checks++; if (DEBUG_MEM_ADDR !== 16'h0044) begin failures++; $display("[TB] FAIL wait_addr_inc: got %04h expected 0044", DEBUG_MEM_ADDR); end
    test_rdata_lane("wait_rdata0");
    test_rdata_lane("wait_rdata1");
`endif
  endtask

  task automatic test_reset_mid_transaction();
    logic [7:0] d;
    host_write(3'd5, 8'h00);
    DEBUG_SRC_DATA[15:0] = 16'hDEAD;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    host_write(3'd1, 8'h04);
    checks++; if (DEBUG_REQ !== 1'b1) begin failures++; $display("[TB] FAIL rst_req_high: got %b expected 1", DEBUG_REQ); end
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    checks++; if (DEBUG_REQ !== 1'b0) begin failures++; $display("[TB] FAIL rst_req_drop: got %b expected 0", DEBUG_REQ); end
    pulse_ack();
    step();
    host_read(3'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("[TB] FAIL rst_ctrl: got %02h expected 00", d); end
    checks++; if (DEBUG_MEM_ADDR !== 16'h0000) begin failures++; $display("[TB] FAIL rst_addr: got %04h expected 0000", DEBUG_MEM_ADDR); end
    test_rdata_lane("rst_rdata0");
    test_rdata_lane("rst_rdata1");
  endtask

  // Runs every scenario in order, then reports the totals.
  initial begin
    test_reset();
    test_stop_and_wdata();
    test_autoinc_transaction();
    test_addr_wrap();
    test_non_mem_op();
    test_busy_errors();
    test_timeout();
    test_reset_mid_transaction();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover bytes expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debug_port_ng.md
# debug_port_ng

Parametrised debug bridge between an 8-bit host register interface and the CPU core. It replaces the fixed 16-bit debug port with configurable address and data widths, serial byte-lane loading of the address and write data, and a request/acknowledge transaction engine. It also adds auto-increment by a configurable step, lane-sequenced readback and a sticky error status. It sits beside the instruction phase decoder, which receives `DEBUG_REQ`, `DEBUG_OP` and `DEBUG_SEL` and returns `DEBUG_ACK`.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: memory address width; multiple of 8.
- `DATA_WIDTH`, 16: data width; multiple of 8. `LANES = DATA_WIDTH/8`.
- `ADDR_STEP`, 2: auto-increment amount.
- `TIMEOUT`, 255: number of REQ cycles without ACK before abort.

Ports:
- `CLK`  in  1  sole clock; everything is rising-edge.
- `RESET`  in  1  synchronous, active-high reset.
- `HOST_ADDR`  in  3  host register select.
- `HOST_DIN`  in  8  host write data.
- `HOST_DOUT`  out  8  host read data; combinational from `HOST_ADDR`.
- `HOST_WR`  in  1  one-cycle write strobe.
- `HOST_RD`  in  1  one-cycle read strobe; affects only the RDATA pointer.
- `DEBUG_STOP`  out  1  halt request to the core.
- `DEBUG_STOPPED`  in  1  core-halted indication.
- `DEBUG_REQ`  out  1  transaction request.
- `DEBUG_ACK`  in  1  transaction acknowledge, one-cycle pulse.
- `DEBUG_OP`  out  3  operation code. Bit 2 marks a memory op.
- `DEBUG_SEL`  out  5  register/sub-operation select.
- `DEBUG_MEM_ADDR`  out  `ADDR_WIDTH`  memory address counter.
- `DEBUG_MEM_DATA_OUT`  out  `DATA_WIDTH`  write-data buffer.
- `DEBUG_SRC_DATA`  in  `4*DATA_WIDTH`  four capture sources; source n occupies slice n.

## Operation
Host register map (writes on `HOST_WR`):
- **0 CTRL**
  - Write: bit0 sets `DEBUG_STOP`; bit1 sets AUTOINC; bit2 = 1 clears ERR_BUSY and ERR_TMO.
  - Read: {4'b0, ERR_TMO, ERR_BUSY, BUSY, `DEBUG_STOPPED`}.
- **1 OP**
  - Write: `{DEBUG_SEL, DEBUG_OP} <= HOST_DIN` and launch a transaction.
  - If BUSY, the write is ignored entirely and ERR_BUSY is set.
  - Read: returns the current {SEL, OP}.
- **2 ADDR**
  - Write: `addr <= {addr[ADDR_WIDTH-9:0], HOST_DIN}` (bytes enter MSB first).
  - Read: `addr[7:0]`.
  - Write while BUSY: ignored, sets ERR_BUSY.
- **3 WDATA**
  - Write: same shift scheme into `DEBUG_MEM_DATA_OUT`.
  - Write while BUSY: ignored, sets ERR_BUSY.
- **4 RDATA**
  - Read: returns lane `rptr` of the result register.
  - Each `HOST_RD` advances `rptr`; it wraps from `LANES-1` to 0.
- **5 SRC**
  - Write: bits[1:0] select which `DEBUG_SRC_DATA` slice is captured.
- **6, 7**: reads return 0; writes are ignored.

Transaction state machine:
- **IDLE**: an OP write moves to REQ.
- **REQ**: `DEBUG_REQ` = 1. On `DEBUG_ACK`:
  - capture the SRC-selected slice into the result register;
  - clear `rptr`;
  - move to POST.
- **POST**: if AUTOINC and `DEBUG_OP[2]`, `addr <= addr + ADDR_STEP` modulo 2^`ADDR_WIDTH`. Then return to IDLE.
- BUSY = (state != IDLE).
- `DEBUG_ACK` seen in IDLE or POST is ignored.
- Reset values: state IDLE, all outputs 0, all registers 0, `rptr` 0, errors clear.
- RESET mid-transaction drops `DEBUG_REQ` on the next edge, and no capture occurs.
- A CTRL write and a launch in the same cycle cannot occur, because there is a single write port.

## Timing
- OP write at edge N → `DEBUG_REQ` high after edge N.
- ACK sampled at edge M → `DEBUG_REQ` low and result valid after M; address increment visible after M+1; BUSY low after M+1.
- Minimum transaction: 3 cycles from OP write to IDLE, i.e. ACK arriving in the first REQ cycle.
- `DEBUG_STOP` changes one cycle after the CTRL write.
- `HOST_DOUT` has zero latency. An `HOST_RD` pointer advance is visible from the next cycle.

## Configuration
- **`DEBUG_PORT_TIMEOUT_EN` defined**:
  - an 8-bit-or-wider counter runs in REQ;
  - on reaching `TIMEOUT` with no ACK: go REQ→IDLE, drop `DEBUG_REQ`, set ERR_TMO, no capture, no increment.
  - ACK and timeout in the same cycle: ACK wins.
- **Undefined**: no counter; REQ waits indefinitely and ERR_TMO reads 0.

## Test plan
- Reset, then read every register → CTRL=0x00, OP=0x00, RDATA=0x00, `DEBUG_MEM_ADDR`=0, `DEBUG_REQ`=0.
- Write ADDR 0x12 then 0x34; write CTRL 0x02; write OP 0x04; ACK after 2 cycles with SRC0=0xBEEF → `DEBUG_MEM_ADDR`=0x1234, then 0x1236. RDATA reads return 0xEF, 0xBE, 0xEF.
- ADDR=0xFFFE with AUTOINC on, run a memory op → `DEBUG_MEM_ADDR` wraps to 0x0000.
- Write OP while REQ is pending; also write ADDR while BUSY → ERR_BUSY (CTRL bit2) = 1 and the address is unchanged. Write CTRL 0x04 → ERR_BUSY clears.
- With `DEBUG_PORT_TIMEOUT_EN` and TIMEOUT=4, never ACK → `DEBUG_REQ` drops after 4 REQ cycles, CTRL reads 0x08, and the result register is unchanged.
- Assert RESET during REQ → `DEBUG_REQ`=0 next cycle; a subsequent ACK pulse causes no capture.
